// File: rtl/usr_pkg.sv
// Shared types and sizing helpers for the PISO serializer.
// Parity bit is appended to every frame when PISO_SERIALIZER_PARITY_EN is defined.
package usr_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

    // One extra count of headroom so the parity frame never wraps the counter.
    function automatic int cnt_width(input int flen);
        return $clog2(flen + 1);
    endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Frame bit counter: clear on load, increment per emitted bit, flag the final bit.
module ser_bit_counter #(
    parameter int CNT_W    = 3,
    parameter int LAST_VAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(LAST_VAL));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmit stage with valid/ready input and bit-valid/last output.
// Build option PISO_SERIALIZER_PARITY_EN appends an even-parity bit to each frame.
module piso_serializer
    import usr_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy
);

    localparam int FRAME_LEN = frame_len(WIDTH);
    localparam int CNT_W     = cnt_width(FRAME_LEN);

    piso_state_t          state, state_nxt;
    logic [FRAME_LEN-1:0] shreg;
    logic                 term;
    logic                 accept;
    logic                 cnt_clr;
    logic                 cnt_inc;
    logic                 out_bit;

    // Lay the word out so the first bit to emit sits at the output end.
    function automatic logic [FRAME_LEN-1:0] build_frame(input logic [WIDTH-1:0] word);
`ifdef PISO_SERIALIZER_PARITY_EN
        if (MSB_FIRST) begin
            return {word, ^word};
        end
        return {^word, word};
`else
        return word;
`endif
    endfunction

    assign busy     = (state == SHIFT);
    assign in_ready = (state == IDLE) || term;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    cnt_clr   = 1'b1;
                end
            end
            SHIFT: begin
                if (term) begin
                    cnt_clr = 1'b1;
                    if (!accept) begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= build_frame(in_data);
        end else if (state == SHIFT) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[FRAME_LEN-1:1]};
            end
        end
    end

    ser_bit_counter #(
        .CNT_W    (CNT_W),
        .LAST_VAL (FRAME_LEN - 1)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .last (term)
    );

    assign out_bit   = MSB_FIRST ? shreg[FRAME_LEN-1] : shreg[0];
    assign ser_out   = busy & out_bit;
    assign ser_valid = busy;
    assign ser_last  = busy & term;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first instances, the latter
// feeding a left-shifting downstream register model.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, ser_out, ser_valid, ser_last, busy;
    logic [3:0] in_data;
    logic       b_valid, b_ready, b_ser_out, b_ser_valid, b_ser_last, b_busy;
    logic [3:0] b_data;
    logic [3:0] ds_q;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_valid),
        .in_ready  (b_ready),
        .in_data   (b_data),
        .ser_out   (b_ser_out),
        .ser_valid (b_ser_valid),
        .ser_last  (b_ser_last),
        .busy      (b_busy)
    );

    // Downstream register in left-shift mode (sel = 2'b10) while ser_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ds_q <= '0;
        end else if (b_ser_valid) begin
            ds_q <= {ds_q[2:0], b_ser_out};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected i-th emitted bit of a frame built from word w.
    function automatic logic exp_bit(input logic [3:0] w, input int i, input bit msb);
        logic [FL-1:0] f;
`ifdef PISO_SERIALIZER_PARITY_EN
        f = msb ? {w, ^w} : {^w, w};
`else
        f = w;
`endif
        return msb ? f[FL-1-i] : f[i];
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, {7'b0, ser_valid}, 8'd0);
        chk({tag, "_out"},   {7'b0, ser_out},   8'd0);
        chk({tag, "_last"},  {7'b0, ser_last},  8'd0);
        chk({tag, "_ready"}, {7'b0, in_ready},  8'd1);
        chk({tag, "_busy"},  {7'b0, busy},      8'd0);
    endtask

    // Accept word w at the next edge, then check every bit of the frame.
    task automatic send_and_check(input logic [3:0] w, input string tag, input bit toggle);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            if (toggle) in_data = ~in_data;
            chk($sformatf("%s_bit%0d", tag, i), {7'b0, ser_out}, {7'b0, exp_bit(w, i, 1'b0)});
            chk($sformatf("%s_vld%0d", tag, i), {7'b0, ser_valid}, 8'd1);
            chk($sformatf("%s_lst%0d", tag, i), {7'b0, ser_last}, {7'b0, (i == FL-1)});
            chk($sformatf("%s_rdy%0d", tag, i), {7'b0, in_ready}, {7'b0, (i == FL-1)});
            step();
        end
        check_idle({tag, "_end"});
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        b_valid  = 1'b0;
        b_data   = '0;
        step();
        step();
        check_idle("reset");
        rst = 1'b0;
        step();
        check_idle("post_reset");

        // Single word, LSB first.
        send_and_check(4'b1011, "w1011", 1'b0);

        // MSB-first instance into the downstream register.
        b_valid = 1'b1;
        b_data  = 4'b1000;
        step();
        b_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("msb_bit%0d", i), {7'b0, b_ser_out}, {7'b0, exp_bit(4'b1000, i, 1'b1)});
            chk($sformatf("msb_lst%0d", i), {7'b0, b_ser_last}, {7'b0, (i == FL-1)});
            step();
        end
        chk("msb_end_valid", {7'b0, b_ser_valid}, 8'd0);
`ifdef PISO_SERIALIZER_PARITY_EN
        chk("ds_q", {4'b0, ds_q}, 8'h01);
`else
        chk("ds_q", {4'b0, ds_q}, 8'h08);
`endif

        // Back-to-back: 4'hA then 4'h5 with in_valid held high.
        in_valid = 1'b1;
        in_data  = 4'hA;
        step();
        in_data = 4'h5;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("b2b_a_bit%0d", i), {7'b0, ser_out}, {7'b0, exp_bit(4'hA, i, 1'b0)});
            chk($sformatf("b2b_a_vld%0d", i), {7'b0, ser_valid}, 8'd1);
            chk($sformatf("b2b_a_rdy%0d", i), {7'b0, in_ready}, {7'b0, (i == FL-1)});
            step();
        end
        in_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            chk($sformatf("b2b_5_bit%0d", i), {7'b0, ser_out}, {7'b0, exp_bit(4'h5, i, 1'b0)});
            chk($sformatf("b2b_5_vld%0d", i), {7'b0, ser_valid}, 8'd1);
            chk($sformatf("b2b_5_lst%0d", i), {7'b0, ser_last}, {7'b0, (i == FL-1)});
            step();
        end
        check_idle("b2b_end");

        // Reset on the 2nd bit of 4'hF, with a word presented alongside rst.
        in_valid = 1'b1;
        in_data  = 4'hF;
        step();
        in_valid = 1'b0;
        chk("rmf_bit0", {7'b0, ser_out}, 8'd1);
        step();
        chk("rmf_bit1", {7'b0, ser_out}, 8'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h3;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_idle("rmf_after");
        for (int i = 0; i < FL; i++) begin
            step();
            chk($sformatf("rmf_quiet%0d", i), {7'b0, ser_valid}, 8'd0);
        end

        // Word presented in an idle cycle with rst high is dropped.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h9;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check_idle("rst_drop");
        step();
        chk("rst_drop_quiet", {7'b0, ser_valid}, 8'd0);

        // Parity vector (plain data frame when parity is not built in).
        send_and_check(4'b0111, "w0111", 1'b0);

        // in_data toggled every cycle while busy.
        send_and_check(4'b0110, "toggle", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
